// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the nibble-serial adder:
//   state_e   - controller states (IDLE, RUN, DONE)
//   SLICE_W   - width of the single adder slice, in bits
//   idx_width - width of the nibble index counter, never less than 1 bit
package serial_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-nibble build still needs a 1-bit index, because a zero-width
  // vector cannot be declared.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_prefix_add.sv
// nibble_prefix_add
// Purely combinational 4-bit parallel-prefix adder with two prefix levels.
// Ports:
//   x[3:0], y[3:0] - addends
//   cIn            - carry into bit 0
//   s[3:0]         - sum
//   cOut           - carry out of bit 3
module nibble_prefix_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cIn,
  output logic [3:0] s,
  output logic       cOut
);

  logic [3:0] g;
  logic [3:0] p;
  // Level 0: bit 0 absorbs the carry-in, so its group generate is final.
  logic       g0_c;
  // Level 1: span-2 groups.
  logic       g1_l1;
  logic       g2_l1;
  logic       p2_l1;
  logic       g3_l1;
  logic       p3_l1;
  // Level 2: span-4 groups reaching back to the carry-in.
  logic       g2_l2;
  logic       g3_l2;
  logic [3:0] c;

  always_comb begin
    g     = x & y;
    p     = x ^ y;
    g0_c  = g[0] | (p[0] & cIn);

    g1_l1 = g[1] | (p[1] & g0_c);
    g2_l1 = g[2] | (p[2] & g[1]);
    p2_l1 = p[2] & p[1];
    g3_l1 = g[3] | (p[3] & g[2]);
    p3_l1 = p[3] & p[2];

    g2_l2 = g2_l1 | (p2_l1 & g0_c);
    g3_l2 = g3_l1 | (p3_l1 & g1_l1);

    c     = {g2_l2, g1_l1, g0_c, cIn};
    s     = p ^ c;
    cOut  = g3_l2;
  end

endmodule

// File: rtl/serial_prefix_add_ctrl.sv
// serial_prefix_add_ctrl
// Adds two WIDTH-bit operands one nibble per clock, least significant nibble
// first, using a single nibble_prefix_add slice. The carry between nibbles is
// held in a register.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. inReady and outValid are decoded from state only, so neither
// depends combinationally on inValid or outReady. The source must hold its
// operands while inValid=1; the consumer reads sum/cOut while outValid=1.
//
// Ports:
//   clk, rstN            - clock, asynchronous active-low reset
//   inValid / inReady    - operand handshake (a, b, cIn sampled on accept)
//   sub                  - only with SERIAL_ADD_SUB_EN: 1 selects a-b
//   outValid / outReady  - result handshake
//   sum, cOut            - registered result and carry out of bit WIDTH-1
//   dbg_state            - current controller state, for observation
//
// Macro SERIAL_ADD_SUB_EN: when defined, adds the sub port and subtract mode.
// In subtract mode, cOut=1 means no borrow.
module serial_prefix_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output state_e           dbg_state
);

  localparam int NIB  = WIDTH / SLICE_W;
  localparam int IDXW = idx_width(NIB);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("serial_prefix_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [SLICE_W-1:0] slice_x;
  logic [SLICE_W-1:0] slice_y;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_c;

  logic               last_nib;

  assign slice_x  = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_y  = b_q[idx_q*SLICE_W +: SLICE_W];
  assign last_nib = (idx_q == IDXW'(NIB - 1));

  nibble_prefix_add u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cIn  (carry_q),
    .s    (slice_s),
    .cOut (slice_c)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (inValid) begin
          a_d     = a;
`ifdef SERIAL_ADD_SUB_EN
          // a - b == a + ~b + 1; the caller's cIn is ignored when subtracting.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cIn;
`else
          b_d     = b;
          carry_d = cIn;
`endif
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_c;
        idx_d   = idx_q + IDXW'(1);
        if (last_nib) begin
          // Restart the index at 0 explicitly so non-power-of-two nibble
          // counts never leave it out of range.
          idx_d   = '0;
          cout_d  = slice_c;
          state_d = DONE;
        end
      end
      DONE: begin
        // sum and cOut stay put here and in IDLE until the next accept.
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign inReady   = (state_q == IDLE);
  assign outValid  = (state_q == DONE);
  assign sum       = sum_q;
  assign cOut      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: doc/serial_prefix_add_ctrl.md
Name: serial_prefix_add_ctrl

Overview:
Sequencer that performs WIDTH-bit additions using a single 4-bit parallel-prefix adder slice, one nibble per clock, LSB nibble first. The inter-nibble carry is held in a register. Operands enter and results leave through valid/ready handshakes. It sits between the operand source (register file / test harness) and any result consumer, trading latency for the area of one 4-bit slice.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB, WIDTH/4, derived localparam: number of nibble steps per operation

Ports:
clk  input  1  rising-edge clock
rstN  input  1  asynchronous active-low reset
inValid  input  1  operand request valid
inReady  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cIn  input  1  carry into bit 0
outValid  output  1  result valid
outReady  input  1  consumer accepts result
sum  output  WIDTH  registered result
cOut  output  1  registered carry out of bit WIDTH-1

Behaviour:
- States: IDLE, RUN, DONE. Reset (rstN=0, asynchronous) forces IDLE, nibble index=0, carry reg=0, sum=0, cOut=0, outValid=0. inReady is 1 in IDLE.
- inReady = (state==IDLE). outValid = (state==DONE). Both are decoded from state only, with no combinational path from inValid/outReady.
- IDLE: on inValid && inReady, capture a, b into operand registers, carry reg <= cIn, idx <= 0, sum <= 0, go to RUN.
- RUN, each cycle: the slice adds a[4*idx+:4], b[4*idx+:4] and the carry reg; write the slice sum into sum[4*idx+:4]; carry reg <= slice carry out; idx <= idx+1.
- When idx==NIB-1 in RUN: also cOut <= slice carry out, go to DONE.
- Latency: outValid rises exactly NIB cycles after the accept edge (WIDTH=16 gives 4 cycles).
- DONE: sum and cOut hold stable while outValid=1 && outReady=0. On outReady=1 go to IDLE; sum and cOut keep their values until the next accept.
- No overlap: there is no accept in the same cycle as result handshake. Minimum issue interval is NIB+2 cycles.
- inValid while not IDLE is ignored. Operand inputs are don't-care except on the accept cycle, because they are registered.
- Wrap-around: the result is modulo 2^WIDTH, and the carry out of the top nibble appears only on cOut.
- Reset mid-RUN or mid-DONE: operation is aborted, all outputs return to reset values, and no partial result is presented.
- idx width is clog2(NIB) with a minimum of 1 bit. For WIDTH=4, RUN lasts one cycle.

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined: adds input port sub (1 bit), sampled on accept.
  - sub=1: b is captured inverted and the carry reg is initialised to 1, ignoring cIn, so the block computes a-b.
  - In subtract mode, cOut=1 means no borrow.
  - sub=0: behaves as plain add.
- Not defined: port sub is absent and the block is add-only.

Decomposition:
- Shared package serial_add_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - SLICE_W=4 constant
  - function computing idx width
- One sub-module, nibble_prefix_add: purely combinational 4-bit parallel-prefix adder (generate/propagate, 2 prefix levels) with ports x[3:0], y[3:0], cIn, s[3:0], cOut.
- It is instantiated once. The controller holds all state.

Test Plan:
- WIDTH=16, a=16'hFFFF, b=16'h0001, cIn=0 -> outValid 4 cycles after accept; sum=16'h0000, cOut=1.
- a=16'h1234, b=16'h4321, cIn=1, outReady held 0 for 3 cycles after outValid -> sum=16'h5556, cOut=0, held stable; inReady=0 throughout; IDLE the cycle after outReady=1.
- inValid pulsed with a=16'hAAAA during RUN of a=16'h0F0F+b=16'h00F1 -> ignored; result sum=16'h1000, cOut=0; only one outValid episode.
- rstN asserted low 2 cycles into RUN -> outValid=0, sum=0, cOut=0 immediately (async); inReady=1 after release; next op 16'h0003+16'h0004 gives 16'h0007.
- WIDTH=4 build, a=4'hF, b=4'hF, cIn=1 -> outValid 1 cycle after accept, sum=4'hF, cOut=1.
- SERIAL_ADD_SUB_EN, sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cOut=0; a=16'h0007, b=16'h0005 -> sum=16'h0002, cOut=1.
